// File: rtl/mem_readout.sv
`default_nettype none
// ============================================================================
// Module   : mem_readout
// Brief    : Reads capture RAM back newest-first after a run completes and
//            serialises each 32-bit sample into bytes for the UART transmitter.
//            Bytes are sent LSB first, byte groups can be suppressed, and the
//            transmitter can stall the stream with a ready/strobe handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mem_readout #(
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_in,
    input  logic                start_i,
    input  logic [ADDR_W-1:0]   last_addr_i,
    input  logic [15:0]         read_cnt_i,
    input  logic [3:0]          grp_dis_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_rd_o,
    input  logic [SAMPLE_W-1:0] mem_data_i,
    output logic [7:0]          tx_data_o,
    output logic                tx_stb_o,
    input  logic                tx_rdy_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_send  = 3'd3;
    localparam logic [2:0] c_st_next  = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    // Request is held 19 bits wide: (0xFFFF+1)*4 = 0x40000 would wrap to zero
    // in 18 bits and turn the largest request into an empty one.
    localparam logic [18:0]     c_depth_req = 19'd1 << ADDR_W;
    localparam logic [ADDR_W:0] c_depth_cnt = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic [SAMPLE_W-1:0] r_shift;
    logic [1:0]          r_idx;
    logic [3:0]          r_dis;
    logic                r_mem_rd;
    logic [7:0]          r_tx_data;
    logic                r_tx_stb;
    logic                r_busy;
    logic                r_done;

    logic [18:0]         w_req;
    logic [ADDR_W:0]     w_count;
    logic [1:0]          w_nidx;
    logic                w_adv;
    logic [ADDR_W:0]     w_rem_dec;

    // Sample count for a new run, clamped to the RAM depth so no address repeats
    always_comb begin
        w_req   = ({3'b000, read_cnt_i} + 19'd1) << 2;
        w_count = c_depth_cnt;
        if (w_req <= c_depth_req) begin
            w_count = w_req[ADDR_W:0];
        end
    end

    // A byte slot finishes when it was skipped (no strobe) or was accepted
    assign w_nidx    = r_idx + 2'd1;
    assign w_adv     = ~r_tx_stb | tx_rdy_i;
    assign w_rem_dec = r_remaining - {{ADDR_W{1'b0}}, 1'b1};

    // Readout sequencer: fetch, wait for RAM data, emit bytes, step address
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= c_st_idle;
            r_addr      <= '0;
            r_remaining <= '0;
            r_shift     <= '0;
            r_idx       <= '0;
            r_dis       <= '0;
            r_mem_rd    <= 1'b0;
            r_tx_data   <= '0;
            r_tx_stb    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_addr      <= last_addr_i;
                        r_dis       <= grp_dis_i;
                        r_remaining <= w_count;
                        r_busy      <= 1'b1;
                        r_mem_rd    <= 1'b1;
                        r_state     <= c_st_fetch;
                    end
                end
                c_st_fetch: begin
                    r_mem_rd <= 1'b0;
                    r_state  <= c_st_wait;
                end
                c_st_wait: begin
                    // Byte 0 is staged here so SEND costs one cycle per group
                    r_shift   <= mem_data_i;
                    r_idx     <= 2'd0;
                    r_tx_data <= mem_data_i[7:0];
                    r_tx_stb  <= ~r_dis[0];
                    r_state   <= c_st_send;
                end
                c_st_send: begin
                    if (w_adv) begin
                        if (r_idx == 2'd3) begin
                            r_tx_stb <= 1'b0;
                            r_state  <= c_st_next;
                        end else begin
                            r_idx     <= w_nidx;
                            r_tx_data <= r_shift[8*w_nidx +: 8];
                            r_tx_stb  <= ~r_dis[w_nidx];
                        end
                    end
                end
                c_st_next: begin
                    r_remaining <= w_rem_dec;
                    r_addr      <= r_addr - {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (w_rem_dec == '0) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_st_done;
                    end else begin
                        r_mem_rd <= 1'b1;
                        r_state  <= c_st_fetch;
                    end
                end
                c_st_done: begin
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_mem_rd <= 1'b0;
                    r_tx_stb <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                    r_state  <= c_st_idle;
                end
            endcase
        end
    end

    assign mem_addr_o = r_addr;
    assign mem_rd_o   = r_mem_rd;
    assign tx_data_o  = r_tx_data;
    assign tx_stb_o   = r_tx_stb;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_readout
// Brief    : Directed bench for mem_readout with a behavioural capture RAM and
//            a byte/fetch recorder on the transmit and RAM read ports.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_readout;

    localparam int ADDR_W   = 10;
    localparam int SAMPLE_W = 32;
    localparam int DEPTH    = 1 << ADDR_W;

    logic                clk_i = 1'b0;
    logic                rst_in = 1'b0;
    logic                start_i = 1'b0;
    logic [ADDR_W-1:0]   last_addr_i = '0;
    logic [15:0]         read_cnt_i = '0;
    logic [3:0]          grp_dis_i = '0;
    logic [ADDR_W-1:0]   mem_addr_o;
    logic                mem_rd_o;
    logic [SAMPLE_W-1:0] mem_data_i = '0;
    logic [7:0]          tx_data_o;
    logic                tx_stb_o;
    logic                tx_rdy_i = 1'b1;
    logic                busy_o;
    logic                done_o;

    mem_readout #(.ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W)) u_dut (
        .clk_i       (clk_i),
        .rst_in      (rst_in),
        .start_i     (start_i),
        .last_addr_i (last_addr_i),
        .read_cnt_i  (read_cnt_i),
        .grp_dis_i   (grp_dis_i),
        .mem_addr_o  (mem_addr_o),
        .mem_rd_o    (mem_rd_o),
        .mem_data_i  (mem_data_i),
        .tx_data_o   (tx_data_o),
        .tx_stb_o    (tx_stb_o),
        .tx_rdy_i    (tx_rdy_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] ram [0:DEPTH-1];
    logic [7:0]  bytes_q [$];
    int          addr_q  [$];
    int          done_cnt = 0;
    int          busy_cyc = 0;
    int          checks   = 0;
    int          errors   = 0;

    // Capture RAM: one-cycle read latency
    always @(posedge clk_i) begin
        if (mem_rd_o) mem_data_i <= ram[mem_addr_o];
    end

    // Recorder of transferred bytes, fetch addresses, done pulses, busy cycles
    always @(posedge clk_i) begin
        if (tx_stb_o && tx_rdy_i) bytes_q.push_back(tx_data_o);
        if (mem_rd_o) addr_q.push_back(int'(mem_addr_o));
        if (done_o) done_cnt <= done_cnt + 1;
        if (busy_o) busy_cyc <= busy_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input int last, input int cnt, input logic [3:0] dis);
        @(negedge clk_i);
        last_addr_i = ADDR_W'(last);
        read_cnt_i  = 16'(cnt);
        grp_dis_i   = dis;
        start_i     = 1'b1;
        @(negedge clk_i);
        start_i     = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget, input string tag);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        repeat (3) @(negedge clk_i);
        chk(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    // Expected stream from the bench RAM: newest first, LSB byte first
    task automatic check_bytes(input int b0, input int last, input int nsamp,
                               input logic [3:0] dis, input string tag);
        logic [7:0]  e [$];
        logic [31:0] w;
        int          mism = 0;
        for (int s = 0; s < nsamp; s++) begin
            w = ram[(last - s) & (DEPTH - 1)];
            for (int n = 0; n < 4; n++)
                if (!dis[n]) e.push_back(w[8*n +: 8]);
        end
        chk({tag, "_count"}, 32'(bytes_q.size() - b0), 32'(e.size()));
        for (int i = 0; i < e.size(); i++)
            if (b0 + i >= bytes_q.size() || bytes_q[b0 + i] !== e[i]) mism++;
        chk({tag, "_data"}, 32'(mism), 32'd0);
    endtask

    initial begin
        int b0, a0, d0, c0, n, bad, dup;
        int exp_wrap [4];
        logic [7:0] held;
        logic seen [0:DEPTH-1];

        for (int a = 0; a < DEPTH; a++) ram[a] = 32'(a) * 32'h01010101;
        ram[7] = 32'hDDCCBBAA;

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("reset_outputs", {10'd0, mem_addr_o, mem_rd_o, tx_data_o, tx_stb_o, busy_o, done_o}, 32'd0);
        rst_in = 1'b1;
        @(negedge clk_i);

        // Basic ordering: samples 5,4,3,2 -> 05x4 04x4 03x4 02x4
        b0 = bytes_q.size(); a0 = addr_q.size(); d0 = done_cnt; c0 = busy_cyc;
        start_run(5, 0, 4'h0);
        chk("busy_after_start", 32'(busy_o), 32'd1);
        wait_done(d0, 200, "basic_done");
        chk("basic_busy_fell", 32'(busy_o), 32'd0);
        chk("basic_busy_cycles", 32'(busy_cyc - c0), 32'd28);
        chk("basic_byte0", 32'(bytes_q[b0]), 32'h05);
        chk("basic_byte4", 32'(bytes_q[b0 + 4]), 32'h04);
        chk("basic_byte15", 32'(bytes_q[b0 + 15]), 32'h02);
        chk("basic_fetches", 32'(addr_q.size() - a0), 32'd4);
        chk("basic_first_addr", 32'(addr_q[a0]), 32'd5);
        check_bytes(b0, 5, 4, 4'h0, "basic");

        // Wrap-around: 1, 0, 1023, 1022
        exp_wrap = '{1, 0, 1023, 1022};
        b0 = bytes_q.size(); a0 = addr_q.size(); d0 = done_cnt;
        start_run(1, 0, 4'h0);
        wait_done(d0, 200, "wrap_done");
        chk("wrap_fetches", 32'(addr_q.size() - a0), 32'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("wrap_addr%0d", i), 32'(addr_q[a0 + i]), 32'(exp_wrap[i]));
        check_bytes(b0, 1, 4, 4'h0, "wrap");

        // Group disable 1010: sample 7 gives AA, CC; sample 6 gives 06, 06
        b0 = bytes_q.size(); d0 = done_cnt;
        start_run(7, 0, 4'b1010);
        wait_done(d0, 200, "gdis_done");
        chk("gdis_count", 32'(bytes_q.size() - b0), 32'd8);
        chk("gdis_byte0", 32'(bytes_q[b0]), 32'hAA);
        chk("gdis_byte1", 32'(bytes_q[b0 + 1]), 32'hCC);
        chk("gdis_byte2", 32'(bytes_q[b0 + 2]), 32'h06);
        check_bytes(b0, 7, 4, 4'b1010, "gdis");

        // Backpressure: first byte held for 20 cycles
        b0 = bytes_q.size(); d0 = done_cnt;
        tx_rdy_i = 1'b0;
        start_run(5, 0, 4'h0);
        n = 0;
        while (!tx_stb_o && n < 20) begin @(negedge clk_i); n++; end
        chk("bp_strobe_seen", 32'(tx_stb_o), 32'd1);
        held = tx_data_o;
        chk("bp_first_byte", 32'(held), 32'h05);
        bad = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (!tx_stb_o || tx_data_o !== held) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_no_transfer", 32'(bytes_q.size() - b0), 32'd0);
        tx_rdy_i = 1'b1;
        wait_done(d0, 200, "bp_done");
        check_bytes(b0, 5, 4, 4'h0, "bp");

        // All groups disabled: fetches but no strobes
        b0 = bytes_q.size(); a0 = addr_q.size(); d0 = done_cnt;
        start_run(3, 0, 4'hF);
        wait_done(d0, 200, "alldis_done");
        chk("alldis_bytes", 32'(bytes_q.size() - b0), 32'd0);
        chk("alldis_fetches", 32'(addr_q.size() - a0), 32'd4);

        // Clamp: 0xFFFF requests more than depth -> exactly 1024 distinct fetches
        b0 = bytes_q.size(); a0 = addr_q.size(); d0 = done_cnt;
        start_run(5, 16'hFFFF, 4'h0);
        wait_done(d0, 9000, "clamp_done");
        chk("clamp_fetches", 32'(addr_q.size() - a0), 32'd1024);
        for (int a = 0; a < DEPTH; a++) seen[a] = 1'b0;
        dup = 0;
        for (int i = a0; i < addr_q.size(); i++) begin
            if (seen[addr_q[i] & (DEPTH - 1)]) dup++;
            seen[addr_q[i] & (DEPTH - 1)] = 1'b1;
        end
        chk("clamp_no_repeat", 32'(dup), 32'd0);
        check_bytes(b0, 5, 1024, 4'h0, "clamp");

        // Abort during SEND of the second sample
        b0 = bytes_q.size(); d0 = done_cnt;
        start_run(5, 0, 4'h0);
        n = 0;
        while (bytes_q.size() < b0 + 5 && n < 100) begin @(negedge clk_i); n++; end
        chk("abort_reached_sample2", 32'(bytes_q.size() - b0), 32'd5);
        #1 rst_in = 1'b0;
        #1 chk("abort_outputs_zero", {10'd0, mem_addr_o, mem_rd_o, tx_data_o, tx_stb_o, busy_o, done_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        rst_in = 1'b1;
        @(negedge clk_i);

        // Fresh run after abort; extra start pulses while busy are ignored
        b0 = bytes_q.size(); a0 = addr_q.size(); d0 = done_cnt;
        start_run(5, 0, 4'h0);
        repeat (3) @(negedge clk_i);
        last_addr_i = ADDR_W'(9);
        read_cnt_i  = 16'd3;
        start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
        repeat (5) @(negedge clk_i);
        start_i = 1'b1; @(negedge clk_i); start_i = 1'b0;
        wait_done(d0, 200, "rerun_done");
        chk("rerun_fetches", 32'(addr_q.size() - a0), 32'd4);
        check_bytes(b0, 5, 4, 4'h0, "rerun");
        repeat (5) @(negedge clk_i);
        chk("rerun_idle_after", 32'(busy_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
